// File: rtl/axi_lite_regfile_slave.sv
// axi_lite_regfile_slave: AXI slave register file, read-only ID at index 0.
// Define REGFILE_ERR_CNT_EN to make index NREGS-1 a saturating SLVERR counter.
module axi_lite_regfile_slave #(
    parameter int ADDRWIDTH = 32,
    parameter int DWIDTH    = 32,
    parameter int IDWIDTH   = 4,
    parameter int NREGS     = 16
) (
    input  logic                  clk_wr,
    input  logic                  rst_wr,
    input  logic [IDWIDTH-1:0]    awid,
    input  logic [ADDRWIDTH-1:0]  awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DWIDTH-1:0]     wdata,
    input  logic [DWIDTH/8-1:0]   wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [IDWIDTH-1:0]    bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [IDWIDTH-1:0]    arid,
    input  logic [ADDRWIDTH-1:0]  araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [IDWIDTH-1:0]    rid,
    output logic [DWIDTH-1:0]     rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready
);
    localparam logic [DWIDTH-1:0] ID_VAL   = DWIDTH'(32'hA1B0_0001);
    localparam logic [3:0]        LAST_IDX = 4'(NREGS - 1);
    localparam logic [1:0]        OKAY     = 2'b00;
    localparam logic [1:0]        SLVERR   = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_WAIT_AW, W_WAIT_W, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;
    logic [DWIDTH-1:0]    regs_q [16];
    logic [ADDRWIDTH-1:0] awaddr_q, w_addr;
    logic [DWIDTH-1:0]    wdata_q, w_data, rdata_q, rd_val;
    logic [DWIDTH/8-1:0]  wstrb_q, w_strb;
    logic [IDWIDTH-1:0]   bid_q, rid_q;
    logic [1:0]           bresp_q, rresp_q;
    logic [3:0]           w_idx, r_idx;
    logic aw_hs, w_hs, ar_hs, w_commit, w_oor, w_err, r_oor;
    logic unused_addr;

    assign awready = !rst_wr && (w_state_q == W_IDLE || w_state_q == W_WAIT_AW);
    assign wready  = !rst_wr && (w_state_q == W_IDLE || w_state_q == W_WAIT_W);
    assign arready = !rst_wr && r_state_q == R_IDLE;
    assign bvalid  = !rst_wr && w_state_q == W_RESP;
    assign rvalid  = !rst_wr && r_state_q == R_DATA;
    assign rlast   = rvalid;
    assign bid     = rst_wr ? '0 : bid_q;
    assign bresp   = rst_wr ? '0 : bresp_q;
    assign rid     = rst_wr ? '0 : rid_q;
    assign rresp   = rst_wr ? '0 : rresp_q;
    assign rdata   = rst_wr ? '0 : rdata_q;

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign ar_hs  = arvalid && arready;
    // The second half of a write comes straight from the bus, the first from its capture register.
    assign w_addr = aw_hs ? awaddr : awaddr_q;
    assign w_data = w_hs ? wdata : wdata_q;
    assign w_strb = w_hs ? wstrb : wstrb_q;
    assign w_idx  = w_addr[5:2];
    assign r_idx  = araddr[5:2];
    assign w_oor  = |w_addr[ADDRWIDTH-1:6] || 32'(w_idx) >= NREGS;
    assign r_oor  = |araddr[ADDRWIDTH-1:6] || 32'(r_idx) >= NREGS;
    assign unused_addr = ^{w_addr[1:0], araddr[1:0]};

`ifdef REGFILE_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [16:0] err_sum;
    assign w_err     = w_oor || w_idx == '0 || w_idx == LAST_IDX;
    assign err_sum   = {1'b0, err_cnt_q} + 17'(w_commit && w_err) + 17'(ar_hs && r_oor);
    assign err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    assign rd_val    = r_oor ? '0 : r_idx == '0 ? ID_VAL : r_idx == LAST_IDX ? DWIDTH'(err_cnt_q) : regs_q[r_idx];
    always_ff @(posedge clk_wr) err_cnt_q <= rst_wr ? '0 : err_cnt_d;
`else
    assign w_err  = w_oor || w_idx == '0;
    assign rd_val = r_oor ? '0 : r_idx == '0 ? ID_VAL : regs_q[r_idx];
`endif

    always_comb begin
        w_state_d = w_state_q;
        w_commit  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                w_commit  = aw_hs && w_hs;
                w_state_d = w_commit ? W_RESP : aw_hs ? W_WAIT_W : w_hs ? W_WAIT_AW : W_IDLE;
            end
            W_WAIT_W: begin
                w_commit  = w_hs;
                w_state_d = w_hs ? W_RESP : W_WAIT_W;
            end
            W_WAIT_AW: begin
                w_commit  = aw_hs;
                w_state_d = aw_hs ? W_RESP : W_WAIT_AW;
            end
            default: w_state_d = bready ? W_IDLE : W_RESP;
        endcase
        r_state_d = r_state_q == R_IDLE ? (ar_hs ? R_DATA : R_IDLE) : (rready ? R_IDLE : R_DATA);
    end

    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bid_q     <= '0;
            bresp_q   <= '0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            if (aw_hs) begin
                awaddr_q <= awaddr;
                bid_q    <= awid;
            end
            if (w_hs) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
            if (w_commit) bresp_q <= w_err ? SLVERR : OKAY;
            if (ar_hs) begin
                rid_q   <= arid;
                rdata_q <= rd_val;
                rresp_q <= r_oor ? SLVERR : OKAY;
            end
        end
    end

    always_ff @(posedge clk_wr) begin
        for (int i = 0; i < 16; i++)
            for (int b = 0; b < DWIDTH/8; b++)
                if (rst_wr) regs_q[i][8*b +: 8] <= '0;
                else if (w_commit && !w_err && w_idx == 4'(i) && w_strb[b]) regs_q[i][8*b +: 8] <= w_data[8*b +: 8];
    end
endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// tb_axi_lite_regfile_slave: vector table, hand-written corner sequences and a
// randomized phase checked against an array model of the register file.
module tb_axi_lite_regfile_slave;
    localparam int NR = 16;
    localparam logic [31:0] ID_VAL = 32'hA1B0_0001;

    logic        clk_wr = 1'b0, rst_wr = 1'b1;
    logic [3:0]  awid = '0, arid = '0, bid, rid;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid, rlast;
    logic [1:0]  bresp, rresp;
    int          n_cmp = 0, n_bad = 0;
    logic [31:0] model [NR];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  id;
        int          lead;
        int          hold;
        logic [1:0]  bresp;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;
    vec_t tbl [9];

    always #5 clk_wr = ~clk_wr;

    axi_lite_regfile_slave #(.ADDRWIDTH(32), .DWIDTH(32), .IDWIDTH(4), .NREGS(NR)) dut (
        .clk_wr(clk_wr), .rst_wr(rst_wr),
        .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit addr_oor(input logic [31:0] a);
        return a[31:6] != 0 || a[5:2] >= NR;
    endfunction

    function automatic logic [1:0] exp_bresp(input logic [31:0] a);
        return (addr_oor(a) || a[5:2] == 0) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        return addr_oor(a) ? 32'h0 : a[5:2] == 0 ? ID_VAL : model[a[5:2]];
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (exp_bresp(a) == 2'b00)
            for (int b = 0; b < 4; b++)
                if (s[b]) model[a[5:2]][8*b +: 8] = d[8*b +: 8];
    endfunction

    // lead > 0: W goes out lead cycles before AW; lead < 0: AW goes first.
    task automatic write_tx(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [3:0] id, input int lead, input int hold, input logic [1:0] eb);
        bit aw_done = 0, w_done = 0, aw_fire, w_fire;
        int cyc = 0;
        while (!(aw_done && w_done) && cyc < 40) begin
            @(negedge clk_wr);
            if (w_done) check("wready_while_waiting_aw", wready, 0);
            if (aw_done) check("awready_while_waiting_w", awready, 0);
            awaddr = a; awid = id; wdata = d; wstrb = s;
            awvalid = !aw_done && cyc >= (lead > 0 ? lead : 0);
            wvalid  = !w_done && cyc >= (lead < 0 ? -lead : 0);
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(posedge clk_wr);
            aw_done |= aw_fire;
            w_done  |= w_fire;
            cyc++;
        end
        @(negedge clk_wr);
        awvalid = 0; wvalid = 0;
        if (!(aw_done && w_done)) begin
            n_cmp++; n_bad++;
            $display("FAIL write_timeout: aw_done=%0d w_done=%0d after %0d cycles", aw_done, w_done, cyc);
            return;
        end
        check("bvalid", bvalid, 1);
        check("bid", bid, id);
        check("bresp", bresp, eb);
        repeat (hold) begin
            @(negedge clk_wr);
            check("bvalid_hold", bvalid, 1);
            check("bid_hold", bid, id);
            check("bresp_hold", bresp, eb);
            check("awready_in_resp", awready, 0);
            check("wready_in_resp", wready, 0);
        end
        bready = 1;
        @(negedge clk_wr);
        bready = 0;
        check("bvalid_after_b", bvalid, 0);
        check("awready_after_b", awready, 1);
    endtask

    task automatic read_tx(input logic [31:0] a, input logic [3:0] id, input int hold,
                           input logic [31:0] ed, input logic [1:0] er);
        int cyc = 0;
        @(negedge clk_wr);
        araddr = a; arid = id; arvalid = 1;
        while (!arready && cyc < 20) begin
            @(negedge clk_wr);
            cyc++;
        end
        if (!arready) begin
            arvalid = 0;
            n_cmp++; n_bad++;
            $display("FAIL ar_timeout: arready low for %0d cycles", cyc);
            return;
        end
        @(negedge clk_wr);
        arvalid = 0;
        check("rvalid", rvalid, 1);
        check("rid", rid, id);
        check("rdata", rdata, ed);
        check("rresp", rresp, er);
        check("rlast", rlast, 1);
        check("arready_in_rdata", arready, 0);
        repeat (hold) begin
            @(negedge clk_wr);
            check("rvalid_hold", rvalid, 1);
            check("rdata_hold", rdata, ed);
            check("rid_hold", rid, id);
        end
        rready = 1;
        @(negedge clk_wr);
        rready = 0;
        check("rvalid_after_r", rvalid, 0);
    endtask

    initial begin
        logic [31:0] a, old_v, new_v;
        int k;
        for (int i = 0; i < NR; i++) model[i] = '0;
        tbl[0] = '{32'h08, 32'hDEADBEEF, 4'hF, 4'd3, 0, 0, 2'b00, 32'hDEADBEEF, 2'b00};
        tbl[1] = '{32'h0C, 32'h11223344, 4'hF, 4'd5, -2, 5, 2'b00, 32'h11223344, 2'b00};
        tbl[2] = '{32'h0C, 32'h0000AB00, 4'h2, 4'd7, 3, 1, 2'b00, 32'h1122AB44, 2'b00};
        tbl[3] = '{32'h0E, 32'hFFFFFFFF, 4'h0, 4'd1, 0, 0, 2'b00, 32'h1122AB44, 2'b00};
        tbl[4] = '{32'h3C, 32'h0F0F0F0F, 4'h9, 4'd2, 1, 0, 2'b00, 32'h0F00000F, 2'b00};
        tbl[5] = '{32'h00, 32'h12345678, 4'hF, 4'd4, 0, 2, 2'b10, ID_VAL, 2'b00};
        tbl[6] = '{32'h40, 32'h00000055, 4'hF, 4'd6, -1, 0, 2'b10, 32'h0, 2'b10};
        tbl[7] = '{32'h1000_0008, 32'hABABABAB, 4'hF, 4'd8, 2, 0, 2'b10, 32'h0, 2'b10};
        tbl[8] = '{32'h05, 32'hCAFEF00D, 4'hC, 4'd15, 1, 0, 2'b00, 32'hCAFE0000, 2'b00};

        repeat (3) @(negedge clk_wr);
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_arready", arready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_bresp_rresp", {bresp, rresp}, 0);
        check("rst_bid_rid", {bid, rid}, 0);
        check("rst_rdata", rdata, 0);
        rst_wr = 0;
        @(negedge clk_wr);
        check("ready_after_rst", {awready, wready, arready}, 3'b111);

        for (int i = 0; i < 9; i++) begin
            write_tx(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].id, tbl[i].lead, tbl[i].hold, tbl[i].bresp);
            model_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
            read_tx(tbl[i].addr, tbl[i].id ^ 4'hA, i % 3, tbl[i].rdata, tbl[i].rresp);
        end

        // Error read and error write accepted in the same cycle.
        @(negedge clk_wr);
        check("par_ready", {arready, awready, wready}, 3'b111);
        araddr = 32'h40; arid = 4'd2; arvalid = 1;
        awaddr = 32'h00; awid = 4'd6; awvalid = 1; wdata = 32'h5555AAAA; wstrb = 4'hF; wvalid = 1;
        @(negedge clk_wr);
        arvalid = 0; awvalid = 0; wvalid = 0;
        check("par_rvalid", rvalid, 1);
        check("par_rresp", rresp, 2'b10);
        check("par_rdata", rdata, 0);
        check("par_bvalid", bvalid, 1);
        check("par_bresp", bresp, 2'b10);
        check("par_bid", bid, 4'd6);
        bready = 1; rready = 1;
        @(negedge clk_wr);
        bready = 0; rready = 0;
        check("par_done", {bvalid, rvalid}, 2'b00);
        read_tx(32'h00, 4'd3, 0, ID_VAL, 2'b00);

        // Read of a register in the same cycle its write commits sees the old value.
        old_v = model[4];
        new_v = $urandom;
        @(negedge clk_wr);
        awaddr = 32'h10; awid = 4'd1; awvalid = 1;
        @(negedge clk_wr);
        awvalid = 0;
        check("rw_awready_wait", awready, 0);
        wdata = new_v; wstrb = 4'hF; wvalid = 1;
        araddr = 32'h10; arid = 4'd5; arvalid = 1;
        @(negedge clk_wr);
        wvalid = 0; arvalid = 0;
        check("rw_old_rdata", rdata, old_v);
        check("rw_rid", rid, 4'd5);
        check("rw_bvalid", bvalid, 1);
        check("rw_bid", bid, 4'd1);
        bready = 1; rready = 1;
        @(negedge clk_wr);
        bready = 0; rready = 0;
        model[4] = new_v;
        read_tx(32'h10, 4'd9, 0, new_v, 2'b00);

        // Randomized traffic against the model.
        for (int n = 0; n < 80; n++) begin
            k = $urandom_range(0, 19);
            a = (k < 16) ? ((32'(k) << 2) | 32'($urandom_range(0, 3)))
              : (k == 16) ? 32'h40 : (32'h0001_0000 | (32'(k) << 2));
            if ($urandom_range(0, 1) == 1) begin
                logic [31:0] d;
                logic [3:0]  s;
                d = $urandom;
                s = 4'($urandom);
                write_tx(a, d, s, 4'($urandom), int'($urandom_range(0, 6)) - 3,
                         int'($urandom_range(0, 2)), exp_bresp(a));
                model_write(a, d, s);
            end else begin
                read_tx(a, 4'($urandom), int'($urandom_range(0, 2)), exp_read(a), addr_oor(a) ? 2'b10 : 2'b00);
            end
        end

        // Reset with a read response pending.
        @(negedge clk_wr);
        araddr = 32'h08; arid = 4'd9; arvalid = 1;
        @(negedge clk_wr);
        arvalid = 0;
        check("pre_rst_rvalid", rvalid, 1);
        check("pre_rst_rdata", rdata, model[2]);
        rst_wr = 1;
        @(negedge clk_wr);
        check("rst_drops_rvalid", rvalid, 0);
        rst_wr = 0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        @(negedge clk_wr);
        check("rvalid_after_rst", rvalid, 0);
        for (int i = 0; i < NR; i++) read_tx(32'(i) << 2, 4'(i), 0, exp_read(32'(i) << 2), 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axi_lite_regfile_slave.md
AXI_LITE_REGFILE_SLAVE -- requirements
Module: axi_lite_regfile_slave

Interface
REQ-001 The block SHALL have parameter ADDRWIDTH, default 32: AXI address width.
REQ-002 The block SHALL have parameter DWIDTH, default 32: data width; wstrb width is DWIDTH/8.
REQ-003 The block SHALL have parameter IDWIDTH, default 4: transaction ID width.
REQ-004 The block SHALL have parameter NREGS, default 16: number of 32-bit registers; power of two, 2 to 16.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: clk_wr  in  1  sole clock, all logic on rising edge.
REQ-006 The block SHALL have rst_wr  in  1  synchronous active-high reset.
REQ-007 The block SHALL have write address ports: awid in IDWIDTH; awaddr in ADDRWIDTH; awvalid in 1; awready out 1.
REQ-008 The block SHALL have write data ports: wdata in DWIDTH; wstrb in DWIDTH/8; wvalid in 1; wready out 1.
REQ-009 The block SHALL have write response ports: bid out IDWIDTH; bresp out 2; bvalid out 1; bready in 1.
REQ-010 The block SHALL have read address ports: arid in IDWIDTH; araddr in ADDRWIDTH; arvalid in 1; arready out 1.
REQ-011 The block SHALL have read data ports: rid out IDWIDTH; rdata out DWIDTH; rresp out 2; rlast out 1; rvalid out 1; rready in 1.

Function
REQ-012 The block SHALL act as the AXI slave sink for the AIB bridge slave's user AXI master port.
REQ-013 The block SHALL use a write FSM with states W_IDLE, W_WAIT_AW, W_WAIT_W and W_RESP.
REQ-014 In W_IDLE, awready and wready SHALL be 1; AW and W are captured independently, in either order.
REQ-015 AW alone SHALL go to W_WAIT_W with awready=0; W alone SHALL go to W_WAIT_AW with wready=0; both together SHALL go to W_RESP.
REQ-016 A write SHALL commit in the cycle the second of AW/W handshakes; bvalid=1 and bid=captured awid in the next cycle.
REQ-017 In W_RESP, awready=wready=0 and bvalid/bid/bresp SHALL hold until bready=1, then return to W_IDLE.
REQ-018 Byte lanes SHALL be written only where wstrb=1; wstrb=0 SHALL commit nothing and respond OKAY.
REQ-019 The read FSM SHALL have states R_IDLE and R_DATA; arready=1 only in R_IDLE.
REQ-020 An AR handshake in cycle N SHALL give rvalid=1 in cycle N+1, with rid=arid and rlast=1.
REQ-021 rdata SHALL be the register value sampled in cycle N; a write committing in cycle N SHALL not be visible.
REQ-022 rdata, rid and rresp SHALL hold stable until rready=1, then the FSM returns to R_IDLE.
REQ-023 Register index SHALL be addr[5:2]; addr[1:0] are ignored and misaligned accesses respond OKAY.
REQ-024 Out of range is addr[ADDRWIDTH-1:6]!=0 or index>=NREGS; it SHALL return SLVERR (2'b10), drop writes and read 0.
REQ-025 Register 0 SHALL be read-only ID 32'hA1B0_0001; writes to it SHALL return SLVERR with no change.
REQ-026 Read and write FSMs SHALL run independently; simultaneous AR and AW/W SHALL both be accepted in the same cycle.

Reset
REQ-027 When rst_wr=1, all registers and rdata SHALL be 0, FSMs go to W_IDLE/R_IDLE, and pending transactions are discarded.
REQ-028 When rst_wr=1, awready, wready, arready, bvalid and rvalid SHALL be 0, with bresp=rresp=0 and bid=rid=0.
REQ-029 Ready outputs SHALL go to 1 the first cycle after rst_wr falls.
REQ-030 Reset during W_RESP or R_DATA SHALL drop the response the next cycle with no partial write.

Configuration
REQ-031 With REGFILE_ERR_CNT_EN defined, index NREGS-1 SHALL be a read-only, saturating 16-bit count (zero-extended) of SLVERR responses.
REQ-032 With REGFILE_ERR_CNT_EN defined, writes to that counter SHALL return SLVERR and increment it; read and write errors in the same cycle SHALL add 2.
REQ-033 Without REGFILE_ERR_CNT_EN, index NREGS-1 SHALL be an ordinary read-write register and no counter logic is present.

Verification
REQ-034 AW(addr 0x08, id 3) and W(0xDEADBEEF, strb F) in the same cycle, bready=1 -> bvalid next cycle, bid=3, OKAY; read 0x08 gives 0xDEADBEEF, rlast=1.
REQ-035 W issued 3 cycles before AW(0x0C), then wstrb=4'b0010 data 0x0000AB00 -> wready low while waiting; reg3 byte1=0xAB, other bytes unchanged.
REQ-036 Hold bready=0 for 5 cycles after a write -> bvalid/bid stable, awready=wready=0; a second AW is accepted only after the B handshake.
REQ-037 Read 0x40 and write 0x00 -> both SLVERR, rdata=0, reg0 still reads 0xA1B0_0001; with REGFILE_ERR_CNT_EN, reg15 reads 2.
REQ-038 AR(0x10) and a committing write to 0x10 in the same cycle -> old value returned; a subsequent read returns the new value.
REQ-039 Assert rst_wr while rvalid=1 and rready=0 -> rvalid=0 the next cycle and all registers read 0 after reset.
